// File: rtl/xnor_popcount_acc.sv
// rtl/xnor_popcount_acc.sv - XNOR bit-plane popcount, level scaling and fold accumulation
module xnor_popcount_acc #(
    parameter int weight_levels = 2,
    parameter int simd_width    = 32,
    parameter int FOLDS         = 16,
    parameter int ACC_W         = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [weight_levels*simd_width-1:0]   in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [ACC_W-1:0]               out_data
);

    localparam int CNT_W = (FOLDS > 1) ? $clog2(FOLDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FOLDS - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         fold_cnt_q, fold_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0]  out_data_q, out_data_d;

    logic signed [ACC_W-1:0]  beat_sum;
    logic signed [ACC_W-1:0]  pc;
    logic signed [ACC_W-1:0]  contrib;
    logic                     accept;
    logic                     last_beat;

    // A new beat can only enter while not flushing and when the output slot is free or draining.
    assign in_ready  = !clr && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (fold_cnt_q == LAST_CNT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Popcount each plane, map to a +/-1 dot product and weight by level (plane 0 is the MSB level).
    always_comb begin
        beat_sum = '0;
        pc       = '0;
        contrib  = '0;
        for (int w = 0; w < weight_levels; w++) begin
            pc = '0;
            for (int b = 0; b < simd_width; b++) begin
                pc = pc + {{(ACC_W-1){1'b0}}, in_data[w*simd_width + b]};
            end
            contrib  = (pc <<< 1) - $signed(ACC_W'(simd_width));
            beat_sum = beat_sum + (contrib <<< (weight_levels - 1 - w));
        end
    end

    // Next-state: output drain, flush, then accumulate or close the fold.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fold_cnt_d  = fold_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (state_q == HOLD && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
        end

        if (clr) begin
            acc_d      = '0;
            fold_cnt_d = '0;
        end else if (accept) begin
            if (last_beat) begin
                out_data_d  = acc_q + beat_sum;
                out_valid_d = 1'b1;
                acc_d       = '0;
                fold_cnt_d  = '0;
                state_d     = HOLD;
            end else begin
                acc_d      = acc_q + beat_sum;
                fold_cnt_d = fold_cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial fold and any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            fold_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fold_cnt_q  <= fold_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// tb/tb_xnor_popcount_acc.sv - directed scoreboard bench for xnor_popcount_acc
module tb_xnor_popcount_acc;

    localparam int WL    = 2;
    localparam int SW    = 32;
    localparam int FOLDS = 16;
    localparam int ACC_W = 16;

    logic                  clk;
    logic                  rst;
    logic                  clr;
    logic                  in_valid;
    logic                  in_ready;
    logic [WL*SW-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [ACC_W-1:0] out_data;

    int checks;
    int errors;
    int exp_q[$];
    int acc_m;
    int fold_m;

    xnor_popcount_acc #(
        .weight_levels(WL),
        .simd_width   (SW),
        .FOLDS        (FOLDS),
        .ACC_W        (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_beat(input logic [WL*SW-1:0] d);
        int s;
        logic [SW-1:0] plane;
        s = 0;
        for (int w = 0; w < WL; w++) begin
            plane = d[w*SW +: SW];
            s += (2 * $countones(plane) - SW) * (1 << (WL - 1 - w));
        end
        return s;
    endfunction

    function automatic int wrap16(input int v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return int'(t);
    endfunction

    // Drive one beat, wait for acceptance (bounded), then update the reference model.
    task automatic send_beat(input logic [WL*SW-1:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL beat_accept_timeout got 0 expected 1");
        end else begin
            acc_m += model_beat(d);
            fold_m++;
            if (fold_m == FOLDS) begin
                exp_q.push_back(wrap16(acc_m));
                acc_m  = 0;
                fold_m = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: a handshake at the coming edge pops and compares against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result got %0d expected none", out_data);
            end else begin
                check("result", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [WL*SW-1:0] ones;
        logic [WL*SW-1:0] zeros;
        logic [WL*SW-1:0] p0ones;
        logic [WL*SW-1:0] rnd;
        checks    = 0;
        errors    = 0;
        acc_m     = 0;
        fold_m    = 0;
        ones      = '1;
        zeros     = '0;
        p0ones    = {{SW{1'b0}}, {SW{1'b1}}};
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: all ones, result one cycle after the 16th beat
        for (int i = 0; i < FOLDS; i++) send_beat(ones);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_value", 32'(out_data), 32'sd1536);
        // 2: all zeros, back to back
        for (int i = 0; i < FOLDS; i++) send_beat(zeros);
        check("t2_value", 32'(out_data), -32'sd1536);
        // 3: plane0 ones, plane1 zeros
        for (int i = 0; i < FOLDS; i++) send_beat(p0ones);
        check("t3_value", 32'(out_data), 32'sd512);
        idle(2);
        check("t3_drained", 32'(out_valid), 32'd0);

        // 4: backpressure on the output for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < FOLDS; i++) send_beat(ones);
        in_valid = 1'b1;
        in_data  = ones;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data", 32'(out_data), 32'sd1536);
            check("t4_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_released", 32'(out_valid), 32'd0);

        // 5: flushed partial fold produces nothing
        for (int i = 0; i < 7; i++) send_beat(ones);
        in_valid = 1'b0;
        clr      = 1'b1;
        #2;
        check("t5_clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clr    = 1'b0;
        acc_m  = 0;
        fold_m = 0;
        for (int i = 0; i < FOLDS; i++) send_beat(ones);
        check("t5_value", 32'(out_data), 32'sd1536);

        // Random beats through the model
        for (int i = 0; i < FOLDS; i++) begin
            rnd = {$urandom(), $urandom()};
            send_beat(rnd);
        end
        idle(2);

        // 6: asynchronous reset mid-fold
        for (int i = 0; i < 9; i++) send_beat(ones);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        acc_m  = 0;
        fold_m = 0;
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < FOLDS; i++) send_beat(ones);
        check("t6_value", 32'(out_data), 32'sd1536);
        idle(2);

        // Reset while a result is pending discards it
        out_ready = 1'b0;
        for (int i = 0; i < FOLDS; i++) send_beat(zeros);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_data", 32'(out_data), 32'd0);
        void'(exp_q.pop_back());
        #4;
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(3);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
